// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider for DIV/DIVU
// Remainder goes to hi, quotient to lo; one shift-subtract iteration per clock.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;

  // Extra guard bit on trial: a valid difference is always below the divisor,
  // so both top bits are zero exactly when the subtraction did not go negative.
  always_comb begin
    a_mag    = (isSigned && dataA[WIDTH-1]) ? -dataA : dataA;
    b_mag    = (isSigned && dataB[WIDTH-1]) ? -dataB : dataB;
    shifted  = {rem, quo[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, divisor};
    trial_ok = (trial[WIDTH+1:WIDTH] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (dataB == '0) begin
              hi      <= dataA;
              lo      <= '1;
              divZero <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              rem     <= '0;
              quo     <= a_mag;
              divisor <= b_mag;
              q_neg   <= isSigned & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
              r_neg   <= isSigned & dataA[WIDTH-1];
              cnt     <= CW'(WIDTH);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], trial_ok};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          hi      <= r_neg ? -rem : rem;
          lo      <= q_neg ? -quo : quo;
          divZero <= 1'b0;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the MIPS datapath; implements DIV and DIVU (signed and unsigned).
- Produces results for HI and LO: remainder goes to HI, quotient goes to LO.
- Sits beside the single-cycle ALU and shares its operand names dataA and dataB.
- Controller starts an operation with a 1-cycle start pulse, stalls while busy, and captures hi/lo on done.
- Uses one restoring shift-subtract iteration per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- isSigned  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dataA  input  WIDTH  dividend; sampled with start.
- dataB  input  WIDTH  divisor; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done (inclusive).
- done  output  1  one-cycle pulse; hi/lo/divZero valid in this cycle.
- divZero  output  1  divisor was zero for the completed operation.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. At rst=1 at a rising edge:
  - state goes to IDLE;
  - busy=0, done=0, divZero=0, hi=0, lo=0;
  - internal remainder/quotient/counter registers cleared.
- Reset mid-operation aborts the operation silently; no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 in cycle T (operands latched at the T edge):
  - divisor==0: go to DONE. In cycle T+1: done=1, divZero=1, lo=all ones, hi=dataA unmodified (both modes).
  - otherwise: latch magnitudes |A| and |B| (unsigned mode: raw values), plus qNeg = isSigned & (A[MSB]^B[MSB]) and rNeg = isSigned & A[MSB]. Clear remainder, load counter = WIDTH, go to CALC.
- CALC, one iteration per cycle:
  - {rem,quo} shifted left by 1;
  - trial = rem - divisor, computed WIDTH+1 bits wide so no carry is lost;
  - if trial is non-negative: rem = trial and quo LSB = 1; else quo LSB = 0;
  - counter decrements; after WIDTH iterations (cycles T+1..T+WIDTH) go to FIX.
- FIX, cycle T+WIDTH+1: negate quo if qNeg; negate rem if rNeg; load hi/lo; go to DONE.
- DONE, cycle T+WIDTH+2 (latency WIDTH+2 = 34 for default): done=1; return to IDLE next cycle.
- busy is high in CALC, FIX and DONE, low in IDLE.
- hi, lo and divZero hold their values until the next accepted start.
  - divZero clears when a non-zero-divisor operation completes; it does not clear at start.
- start while not in IDLE is ignored; it is not queued.
  - start coincident with done is ignored.
  - start in the cycle after done is accepted, giving a back-to-back throughput of one operation per WIDTH+3 cycles.
- Operand changes after acceptance have no effect.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (the negation wraps). Not flagged.
- Identities: hi = A - lo*B (mod 2^WIDTH); in signed mode the remainder sign matches the dividend and the quotient truncates toward zero.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then idle → busy=0, done=0, divZero=0, hi=0, lo=0. Start pulse during rst=1 → no effect.
- DIVU 100/7 → done exactly 34 cycles after the start edge, lo=14, hi=2, divZero=0; busy high for 34 cycles.
- DIV −7/2 (0xFFFFFFF9 / 2) → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Also 7/−2 → lo=−3, hi=1. Also 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x12345678/0 → done in cycle T+1, divZero=1, lo=0xFFFFFFFF, hi=0x12345678. Then 10/3 → lo=3, hi=1, divZero=0.
- Start pulses during CALC and on the done cycle → ignored, result unchanged. Start on the cycle after done → accepted. DIVU 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0.
- Assert rst at cycle T+10 mid-CALC → next cycle all outputs 0, no done pulse. A new start of 9/3 completes normally with lo=3, hi=0.
